// File: rtl/remap_arbiter.sv
// Round-robin arbiter sharing one combinational remap unit between NUM_REQ requesters.
// Pipeline: arbitration -> S1 (operand, id) -> remap -> S2 (result, id) -> valid/ready response.

// Piecewise-linear remap in three segments: slope 1/2 below a quarter of the input range,
// slope 1/8 up to three quarters, then slope 1/4 to full scale (assumes M1_W == M2_W + 2).
module remap #(
  parameter int M1_W = 10,
  parameter int M2_W = 8
) (
  input  logic [M1_W-1:0] m1,
  output logic [M2_W-1:0] m2
);

  localparam logic [M1_W-1:0] KNEE_LO  = M1_W'(1) << (M1_W - 2);
  localparam logic [M1_W-1:0] KNEE_HI  = KNEE_LO + (KNEE_LO << 1);
  localparam logic [M2_W-1:0] BASE_MID = M2_W'(1) << (M2_W - 1);
  localparam logic [M2_W-1:0] BASE_HI  = BASE_MID + (BASE_MID >> 1);

  logic [M1_W-1:0] off_mid;
  logic [M1_W-1:0] off_hi;

  always_comb begin
    off_mid = m1 - KNEE_LO;
    off_hi  = m1 - KNEE_HI;
    if (m1 < KNEE_LO) begin
      m2 = M2_W'(m1 >> 1);
    end else if (m1 < KNEE_HI) begin
      m2 = BASE_MID + M2_W'(off_mid >> 3);
    end else begin
      m2 = BASE_HI + M2_W'(off_hi >> 2);
    end
  end

endmodule

module remap_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int M1_W    = 10,
  parameter int M2_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*M1_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [M2_W-1:0]         resp_data,
  output logic [ID_W-1:0]         resp_id,
  input  logic                    flush,
  output logic [1:0]              occupancy
);

  logic            s1_valid;
  logic [M1_W-1:0] s1_m1;
  logic [ID_W-1:0] s1_id;
  logic            s2_valid;
  logic [M2_W-1:0] s2_m2;
  logic [ID_W-1:0] s2_id;
  logic [ID_W-1:0] last;

  logic            s1_load;
  logic            s2_load;
  logic            found;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] cand;
  logic            accept;
  logic [M1_W-1:0] sel_m1;
  logic [M2_W-1:0] m2;
  int              idx;

  assign s2_load = !s2_valid || resp_ready;
  assign s1_load = !s1_valid || s2_load;

  // First valid requester searching upward from the one after the last winner.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(last) + k) % NUM_REQ;
      cand = ID_W'(idx);
      if (!found && req_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  // rst_n gating keeps req_ready low throughout reset even with requests pending.
  assign accept    = found && s1_load && !flush && rst_n;
  assign req_ready = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant) : '0;
  assign sel_m1    = req_data[int'(grant)*M1_W +: M1_W];

  remap #(
    .M1_W(M1_W),
    .M2_W(M2_W)
  ) u_remap (
    .m1(s1_m1),
    .m2(m2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_m1    <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_m2    <= '0;
      s2_id    <= '0;
      last     <= ID_W'(NUM_REQ - 1);
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= accept;
        if (accept) begin
          s1_m1 <= sel_m1;
          s1_id <= grant;
          last  <= grant;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        s2_m2    <= m2;
        s2_id    <= s1_id;
      end
    end
  end

  assign resp_valid = s2_valid;
  assign resp_data  = s2_m2;
  assign resp_id    = s2_id;
  assign occupancy  = {1'b0, s1_valid} + {1'b0, s2_valid};

endmodule

// File: tb/tb_remap_arbiter.sv
// Self-checking bench for remap_arbiter: directed scenarios plus a randomized run,
// all checked against a capacity-two queue model with an arithmetic remap reference.
module tb_remap_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int M1_W    = 10;
  localparam int M2_W    = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*M1_W-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [M2_W-1:0]         resp_data;
  logic [ID_W-1:0]         resp_id;
  logic                    flush;
  logic [1:0]              occupancy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int id;
    int data;
    bit fresh;
  } entry_t;

  entry_t             pipe[$];
  int                 m_last;
  int                 m_grant;
  bit                 m_out;
  bit                 m_acc;
  bit                 exp_valid;
  int                 exp_id;
  int                 exp_data;
  int                 exp_occ;
  logic [NUM_REQ-1:0] exp_ready;

  remap_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W(ID_W),
    .M1_W(M1_W),
    .M2_W(M2_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_id(resp_id),
    .flush(flush),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic int ref_remap(int x);
    if (x < 256) return x / 2;
    else if (x < 768) return 128 + (x - 256) / 8;
    else return 192 + (x - 768) / 4;
  endfunction

  // The pipeline holds at most two results; the newest entry cannot be answered in
  // the cycle right after it was accepted into an empty pipeline.
  task automatic model_reset();
    pipe.delete();
    m_last = NUM_REQ - 1;
  endtask

  task automatic model_comb();
    exp_occ   = pipe.size();
    exp_valid = (pipe.size() > 0) && !pipe[0].fresh;
    exp_id    = exp_valid ? pipe[0].id : 0;
    exp_data  = exp_valid ? pipe[0].data : 0;
    m_out     = exp_valid && resp_ready;
    m_grant   = -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int j;
      j = (m_last + k) % NUM_REQ;
      if (m_grant < 0 && req_valid[j]) m_grant = j;
    end
    m_acc = rst_n && (m_grant >= 0) && !flush && ((pipe.size() - int'(m_out)) < 2);
    exp_ready = m_acc ? NUM_REQ'(1 << m_grant) : '0;
  endtask

  task automatic model_edge();
    entry_t e;
    if (m_out) void'(pipe.pop_front());
    foreach (pipe[i]) pipe[i].fresh = 1'b0;
    if (flush) begin
      pipe.delete();
    end else if (m_acc) begin
      e.id    = m_grant;
      e.data  = ref_remap(int'(req_data[m_grant*M1_W +: M1_W]));
      e.fresh = 1'b1;
      pipe.push_back(e);
      m_last = m_grant;
    end
  endtask

  task automatic settle();
    model_comb();
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    resp_ready = 1'b0;
    flush      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    resp_ready = 1'b1;
    flush      = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) req_valid = '1;
      @(posedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b0 || occupancy !== 2'd0 || req_ready !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL reset_hold c=%0d got valid=%0b occ=%0d ready=%b exp 0/0/0000",
                 c, resp_valid, occupancy, req_ready);
      end
      checks++;
      if (resp_data !== 8'h00 || resp_id !== 2'd0) begin
        errors++;
        $display("[TB] FAIL reset_data c=%0d got data=%h id=%0d exp 00/0", c, resp_data, resp_id);
      end
    end
    req_valid = '0;
    rst_n     = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if (resp_valid !== 1'b0 || occupancy !== 2'd0 || req_ready !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL idle c=%0d got valid=%0b occ=%0d ready=%b exp 0/0/0000",
                 c, resp_valid, occupancy, req_ready);
      end
      advance();
    end
  endtask

  task automatic test_single_latency();
    do_reset();
    resp_ready = 1'b1;
    req_data   = 40'({$urandom(), $urandom()});
    req_data[2*M1_W +: M1_W] = 10'h155;
    req_valid  = 4'b0100;
    settle();
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL lat_grant got=%b exp=0100", req_ready);
    end
    advance();
    req_valid = '0;
    settle();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lat_early got valid=%0b exp 0", resp_valid);
    end
    advance();
    settle();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_data !== 8'(ref_remap(32'h155))) begin
      errors++;
      $display("[TB] FAIL lat_result got valid=%0b id=%0d data=%0d exp 1/2/%0d",
               resp_valid, resp_id, resp_data, ref_remap(32'h155));
    end
    advance();
    settle();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lat_after got valid=%0b exp 0", resp_valid);
    end
    advance();
  endtask

  task automatic test_round_robin();
    int cnt[NUM_REQ];
    int results;
    results = 0;
    foreach (cnt[i]) cnt[i] = 0;
    do_reset();
    resp_ready = 1'b1;
    req_valid  = '1;
    for (int c = 0; c < 12; c++) begin
      req_data = 40'({$urandom(), $urandom()});
      settle();
      checks++;
      if (req_ready !== NUM_REQ'(1 << (c % NUM_REQ))) begin
        errors++;
        $display("[TB] FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, NUM_REQ'(1 << (c % NUM_REQ)));
      end
      checks++;
      if (resp_valid !== exp_valid) begin
        errors++;
        $display("[TB] FAIL rr_valid c=%0d got=%0b exp=%0b", c, resp_valid, exp_valid);
      end else if (exp_valid) begin
        checks++;
        if (resp_id !== 2'(exp_id) || resp_data !== 8'(exp_data)) begin
          errors++;
          $display("[TB] FAIL rr_result c=%0d got id=%0d data=%0d exp id=%0d data=%0d",
                   c, resp_id, resp_data, exp_id, exp_data);
        end
        if (results < 8) cnt[resp_id]++;
        results++;
      end
      advance();
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      checks++;
      if (cnt[i] != 2) begin
        errors++;
        $display("[TB] FAIL rr_count id=%0d got=%0d exp=2", i, cnt[i]);
      end
    end
    req_valid = '0;
    repeat (3) begin
      settle();
      advance();
    end
  endtask

  task automatic test_backpressure();
    int got[$];
    do_reset();
    req_data   = 40'({$urandom(), $urandom()});
    req_data[0 +: M1_W] = '0;
    req_valid  = 4'b0011;
    resp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      checks++;
      if (req_ready !== exp_ready || occupancy !== 2'(exp_occ) || resp_valid !== exp_valid) begin
        errors++;
        $display("[TB] FAIL bp_stall c=%0d got ready=%b occ=%0d valid=%0b exp %b/%0d/%0b",
                 c, req_ready, occupancy, resp_valid, exp_ready, exp_occ, exp_valid);
      end
      if (c >= 2) begin
        checks++;
        if (occupancy !== 2'd2 || req_ready !== 4'b0000 || resp_id !== 2'd0 || resp_data !== 8'h00) begin
          errors++;
          $display("[TB] FAIL bp_full c=%0d got occ=%0d ready=%b id=%0d data=%h exp 2/0000/0/00",
                   c, occupancy, req_ready, resp_id, resp_data);
        end
      end
      advance();
    end
    resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      settle();
      checks++;
      if (resp_valid !== exp_valid || req_ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL bp_release c=%0d got valid=%0b ready=%b exp %0b/%b",
                 c, resp_valid, req_ready, exp_valid, exp_ready);
      end
      if (resp_valid) got.push_back(int'(resp_id));
      advance();
    end
    checks++;
    if (got.size() != 8) begin
      errors++;
      $display("[TB] FAIL bp_count got=%0d exp=8", got.size());
    end
    foreach (got[i]) begin
      checks++;
      if (got[i] != i % 2) begin
        errors++;
        $display("[TB] FAIL bp_order i=%0d got id=%0d exp id=%0d", i, got[i], i % 2);
      end
    end
    req_valid = '0;
    repeat (3) begin
      settle();
      advance();
    end
  endtask

  task automatic test_flush();
    int nresp;
    nresp = 0;
    do_reset();
    req_data   = 40'({$urandom(), $urandom()});
    req_valid  = '1;
    resp_ready = 1'b0;
    repeat (3) begin
      settle();
      advance();
    end
    flush = 1'b1;
    settle();
    checks++;
    if (req_ready !== 4'b0000 || occupancy !== 2'd2) begin
      errors++;
      $display("[TB] FAIL flush_cycle got ready=%b occ=%0d exp 0000/2", req_ready, occupancy);
    end
    advance();
    flush = 1'b0;
    settle();
    checks++;
    if (occupancy !== 2'd0 || resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_clear got occ=%0d valid=%0b exp 0/0", occupancy, resp_valid);
    end
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL flush_next_grant got=%b exp=0100", req_ready);
    end
    advance();
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      if (resp_valid) begin
        nresp++;
        checks++;
        if (resp_id !== 2'd2 || resp_data !== 8'(exp_data)) begin
          errors++;
          $display("[TB] FAIL flush_resp got id=%0d data=%0d exp id=2 data=%0d", resp_id, resp_data, exp_data);
        end
      end
      advance();
    end
    checks++;
    if (nresp != 1) begin
      errors++;
      $display("[TB] FAIL flush_resp_count got=%0d exp=1", nresp);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_data   = 40'({$urandom(), $urandom()});
    req_valid  = 4'b1010;
    resp_ready = 1'b0;
    repeat (2) begin
      settle();
      advance();
    end
    settle();
    checks++;
    if (occupancy !== 2'd2 || resp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL areset_fill got occ=%0d valid=%0b exp 2/1", occupancy, resp_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || occupancy !== 2'd0 || req_ready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL areset_drop got valid=%0b occ=%0d ready=%b exp 0/0/0000",
               resp_valid, occupancy, req_ready);
    end
    model_reset();
    #2;
    rst_n     = 1'b1;
    req_valid = '1;
    settle();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL areset_grant got=%b exp=0001", req_ready);
    end
    advance();
    req_valid = '0;
    resp_ready = 1'b1;
    repeat (3) begin
      settle();
      advance();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid  = NUM_REQ'($urandom_range(0, 15));
      req_data   = 40'({$urandom(), $urandom()});
      resp_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 24) == 0);
      settle();
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready);
      end
      checks++;
      if (resp_valid !== exp_valid || occupancy !== 2'(exp_occ)) begin
        errors++;
        $display("[TB] FAIL rnd_state c=%0d got valid=%0b occ=%0d exp %0b/%0d",
                 c, resp_valid, occupancy, exp_valid, exp_occ);
      end
      if (exp_valid) begin
        checks++;
        if (resp_id !== 2'(exp_id) || resp_data !== 8'(exp_data)) begin
          errors++;
          $display("[TB] FAIL rnd_result c=%0d got id=%0d data=%0d exp id=%0d data=%0d",
                   c, resp_id, resp_data, exp_id, exp_data);
        end
      end
      advance();
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
